// File: rtl/i2s_transmitter.sv
// I2S master transmitter: one-deep stereo holding buffer, BCLK/LRCLK
// generation from the system clock and MSB-first serialisation on DOUT.
module i2s_transmitter #(
    parameter int CLK_DIV  = 8,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                BCLK,
    output logic                LRCLK,
    output logic                DOUT,
    output logic                underrun
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          bit_cnt;
    logic [5:0]          bit_cnt_nxt;
    logic [0:0]          buf_state;
    logic [SAMPLE_W-1:0] buf_l;
    logic [SAMPLE_W-1:0] buf_r;
    logic [63:0]         shreg;
    logic [63:0]         load_word;
    logic                fall_evt;
    logic                frame_start;
    logic                accept;

    assign in_ready    = rst_n && (buf_state == EMPTY);
    assign accept      = in_valid && in_ready;
    assign fall_evt    = (div_cnt == DIV_MAX) && BCLK;
    assign frame_start = fall_evt && (bit_cnt == 6'd63);
    assign bit_cnt_nxt = bit_cnt + 6'd1;

    // Bit 63 is shifted out at b = 1; the right slot starts 32 bits later.
    always_comb begin
        load_word = '0;
        load_word[63 -: SAMPLE_W] = buf_l;
        load_word[31 -: SAMPLE_W] = buf_r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bit_cnt   <= 6'd63;
            BCLK      <= 1'b0;
            LRCLK     <= 1'b0;
            DOUT      <= 1'b0;
            underrun  <= 1'b0;
            buf_state <= EMPTY;
            buf_l     <= '0;
            buf_r     <= '0;
            shreg     <= '0;
        end else begin
            underrun <= 1'b0;

            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
                BCLK    <= ~BCLK;
            end else begin
                div_cnt <= div_cnt + DIV_ONE;
            end

            if (fall_evt) begin
                bit_cnt <= bit_cnt_nxt;
                LRCLK   <= bit_cnt_nxt[5];
                if (frame_start) begin
                    DOUT <= 1'b0;
                    if (buf_state == FULL) begin
                        shreg     <= load_word;
                        buf_state <= EMPTY;
                    end else begin
                        shreg    <= '0;
                        underrun <= 1'b1;
                    end
                end else begin
                    DOUT  <= shreg[63];
                    shreg <= {shreg[62:0], 1'b0};
                end
            end

            // Only possible when EMPTY, so it never races a FULL frame start.
            if (accept) begin
                buf_state <= FULL;
                buf_l     <= in_left;
                buf_r     <= in_right;
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: frame-level reference model
// predicts each frame's contents, a monitor compares what the DAC sees.
module tb_i2s_transmitter;

    localparam int CD = 8;
    localparam int SW = 16;
    localparam int FRAME = 128 * CD;

    typedef struct packed {
        logic          uflow;
        logic [SW-1:0] l;
        logic [SW-1:0] r;
    } frame_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_left;
    logic [SW-1:0] in_right;
    logic          BCLK;
    logic          LRCLK;
    logic          DOUT;
    logic          underrun;

    i2s_transmitter #(.CLK_DIV(CD), .SAMPLE_W(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_left  (in_left),
        .in_right (in_right),
        .BCLK     (BCLK),
        .LRCLK    (LRCLK),
        .DOUT     (DOUT),
        .underrun (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int     checks = 0;
    int     errors = 0;
    int     frames = 0;
    int     edge_n = 0;
    bit     rst_seen = 0;
    bit     m_full = 0;
    logic [SW-1:0] m_l;
    logic [SW-1:0] m_r;
    frame_t exp_q[$];

    int          mon_b = 63;
    bit          prev_bclk = 0;
    bit          have_cur = 0;
    bit          fall;
    frame_t      cur;
    logic [63:0] got_d;
    logic [63:0] got_lr;
    logic [63:0] lr_exp;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_fs(input int n);
        return (n >= 2 * CD) && (((n - 2 * CD) % FRAME) == 0);
    endfunction

    // Slot b=0 is word bit 63; left data in b=1..SW, right in b=33..32+SW.
    function automatic logic [63:0] exp_dout(input logic [SW-1:0] l,
                                             input logic [SW-1:0] r);
        logic [63:0] w;
        w = '0;
        for (int b = 1; b <= SW; b++) w[63-b] = l[SW-b];
        for (int b = 33; b <= 32 + SW; b++) w[63-b] = r[SW+32-b];
        return w;
    endfunction

    // Reference model: frame starts fall every FRAME edges after 2*CD.
    initial begin
        bit acc;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_full   = 0;
                edge_n   = 0;
                rst_seen = 1;
                exp_q.delete();
            end else begin
                edge_n++;
                acc = in_valid && !m_full;
                if (is_fs(edge_n)) begin
                    if (m_full)
                        exp_q.push_back(frame_t'{uflow: 1'b0, l: m_l, r: m_r});
                    else
                        exp_q.push_back(frame_t'{uflow: 1'b1, l: '0, r: '0});
                    m_full = 0;
                end
                if (acc) begin
                    m_full = 1;
                    m_l    = in_left;
                    m_r    = in_right;
                end
            end
        end
    end

    // Monitor: samples mid-cycle and rebuilds each 64-bit frame.
    initial begin
        lr_exp = 64'h0000_0000_FFFF_FFFF;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_b     = 63;
                prev_bclk = 0;
                have_cur  = 0;
                if (rst_seen) begin
                    check("rst_bclk", BCLK, 0);
                    check("rst_lrclk", LRCLK, 0);
                    check("rst_dout", DOUT, 0);
                    check("rst_underrun", underrun, 0);
                    check("rst_in_ready", in_ready, 0);
                end
            end else begin
                check("in_ready", in_ready, !m_full);
                check("bclk", BCLK, (edge_n / CD) % 2);
                fall = prev_bclk && !BCLK;
                prev_bclk = BCLK;
                if (fall) begin
                    mon_b = (mon_b + 1) % 64;
                    if (mon_b == 0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            have_cur = 0;
                            $display("FAIL frame_q got=empty exp=entry t=%0t",
                                     $time);
                        end else begin
                            cur      = exp_q.pop_front();
                            have_cur = 1;
                            check("underrun_fs", underrun, cur.uflow);
                        end
                        got_d  = '0;
                        got_lr = '0;
                    end
                    got_d[63-mon_b]  = DOUT;
                    got_lr[63-mon_b] = LRCLK;
                    if (mon_b == 63 && have_cur) begin
                        check("dout_frame", got_d, exp_dout(cur.l, cur.r));
                        check("lrclk_frame", got_lr, lr_exp);
                        frames++;
                    end
                end
                if (!(fall && mon_b == 0))
                    check("underrun_idle", underrun, 0);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 5000);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got=0 exp=1 t=%0t", $time);
        end
    endtask

    task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_left  = SW'($urandom);
        in_right = SW'($urandom);
    endtask

    task automatic wait_b(input int b);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (mon_b != b && t < 3 * FRAME);
        if (mon_b != b) begin
            checks++;
            errors++;
            $display("FAIL bit_wait got=%0d exp=%0d", mon_b, b);
        end
    endtask

    initial begin
        logic [SW-1:0] n;
        int            t;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(16'hA5C3, 16'h1234);
        wait_cycles(3 * FRAME);

        // Present a sample only on the wrap edge with the buffer empty.
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!is_fs(edge_n + 1) && t < 2 * FRAME);
        in_valid = 1'b1;
        in_left  = 16'h7FFF;
        in_right = SW'($urandom);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_cycles(2 * FRAME + 50);

        n = SW'($urandom_range(0, 16'hFF00));
        in_valid = 1'b1;
        in_left  = n;
        in_right = n;
        for (int k = 0; k < 5; k++) begin
            wait_ready();
            @(posedge clk);
            #1;
            n++;
            in_left  = n;
            in_right = n;
        end
        in_valid = 1'b0;
        wait_cycles(2 * FRAME);

        for (int k = 0; k < 6; k++) begin
            wait_cycles($urandom_range(0, 1500));
            send(SW'($urandom), SW'($urandom));
        end
        wait_cycles(2 * FRAME);

        wait_b(2);
        send(SW'($urandom), SW'($urandom));
        wait_b(20);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(2 * FRAME);
        send(SW'($urandom), SW'($urandom));
        wait_cycles(2 * FRAME + 50);

        check("frame_count_ok", frames >= 15, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
